// File: rtl/duckhunt_pkg.sv
// Shared types and defaults for the light-gun trigger controller.
//   gun_state_t   : per-gun trigger FSM state encoding
//   DEF_*         : default parameter values for gun_trigger_ctrl
//   clog2_min1()  : counter width helper that never returns 0
package duckhunt_pkg;

  typedef enum logic [1:0] {
    S_WAIT_RELEASE = 2'b00,
    S_READY        = 2'b01,
    S_SHOT         = 2'b11,
    S_COOLDOWN     = 2'b10
  } gun_state_t;

  localparam int DEF_NUM_GUNS        = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_COOLDOWN_CYCLES = 8;
  localparam int DEF_MAX_AMMO        = 3;

  // Bits needed to hold values 0..v-1, with a floor of 1 bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/trigger_debounce.sv
// Two-flop synchronizer followed by a debounce filter for one raw trigger.
//   clk, reset_n : clock, asynchronous active-low reset
//   raw          : asynchronous trigger pin, 1 = pressed
//   level        : filtered trigger level (resets to 1 so a trigger held
//                  through reset reads as "still pressed")
// The filtered level flips on the edge where the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing
// cycle restarts the count.
module trigger_debounce
  import duckhunt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int            CW       = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != level) begin
        // This cycle is the DEBOUNCE_CYCLES-th disagreeing one: accept it.
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gun_trigger_ctrl.sv
// Multi-gun trigger controller: one debounced shot pulse per press, with
// release-before-refire, per-gun ammo and a post-shot cooldown.
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : game-active qualifier; low parks every gun in S_WAIT_RELEASE
//   trigger      : raw trigger pins, 1 = pressed
//   reload       : one-cycle refill request per gun
//   shot         : one-cycle registered fire pulse per gun
//   dry_fire     : one-cycle pulse when a press finds zero ammo
//   ammo         : remaining ammo, gun i at [i*AW +: AW]
//   empty        : 1 while that gun's ammo is 0
// Handshake: there is none; shot/dry_fire are single-cycle strobes that the
// consumer samples on the clock edge after they rise, with no back-pressure.
// Each gun's FSM state is held in g_gun[i].state for observation.
module gun_trigger_ctrl
  import duckhunt_pkg::*;
#(
  parameter  int NUM_GUNS        = DEF_NUM_GUNS,
  parameter  int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter  int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter  int MAX_AMMO        = DEF_MAX_AMMO,
  localparam int AW              = $clog2(MAX_AMMO + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [NUM_GUNS-1:0]    trigger,
  input  logic [NUM_GUNS-1:0]    reload,
  output logic [NUM_GUNS-1:0]    shot,
  output logic [NUM_GUNS-1:0]    dry_fire,
  output logic [NUM_GUNS*AW-1:0] ammo,
  output logic [NUM_GUNS-1:0]    empty
);

  localparam int             CDW       = clog2_min1(COOLDOWN_CYCLES + 1);
  localparam logic [CDW-1:0] CD_LAST   = CDW'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
  localparam logic [AW-1:0]  AMMO_FULL = AW'(MAX_AMMO);
  localparam logic [AW-1:0]  AMMO_ONE  = AW'(1);

  for (genvar g = 0; g < NUM_GUNS; g++) begin : g_gun
    logic           trig_f;
    gun_state_t     state;
    logic [AW-1:0]  ammo_q;
    logic [CDW-1:0] cd_cnt;
    logic           shot_q;
    logic           dry_q;
    logic           empty_q;
    logic           press;
    logic           has_ammo;

    trigger_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (trigger[g]),
      .level  (trig_f)
    );

    // A press is only acted on from S_READY while the game is active.
    assign press    = (state == S_READY) && enable && trig_f;
    assign has_ammo = (ammo_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state   <= S_WAIT_RELEASE;
        ammo_q  <= AMMO_FULL;
        cd_cnt  <= '0;
        shot_q  <= 1'b0;
        dry_q   <= 1'b0;
        empty_q <= 1'b0;
      end else begin
        shot_q <= 1'b0;
        dry_q  <= 1'b0;

        // A shot already showing on the output simply expires here, so
        // dropping enable never truncates a pulse.
        if (!enable) begin
          state  <= S_WAIT_RELEASE;
          cd_cnt <= '0;
        end else begin
          case (state)
            S_WAIT_RELEASE: begin
              if (!trig_f) state <= S_READY;
            end
            S_READY: begin
              if (trig_f) begin
                if (has_ammo) begin
                  state  <= S_SHOT;
                  shot_q <= 1'b1;
                end else begin
                  dry_q <= 1'b1;
                  state <= S_WAIT_RELEASE;
                end
              end
            end
            S_SHOT: begin
              cd_cnt <= '0;
              state  <= (COOLDOWN_CYCLES == 0) ? S_WAIT_RELEASE : S_COOLDOWN;
            end
            S_COOLDOWN: begin
              if (cd_cnt == CD_LAST) state <= S_WAIT_RELEASE;
              else                   cd_cnt <= cd_cnt + 1'b1;
            end
            default: state <= S_WAIT_RELEASE;
          endcase
        end

        // Reload wins over the decrement of a simultaneous shot.
        if (reload[g]) begin
          ammo_q  <= AMMO_FULL;
          empty_q <= 1'b0;
        end else if (press && has_ammo) begin
          ammo_q  <= ammo_q - 1'b1;
          empty_q <= (ammo_q == AMMO_ONE);
        end
      end
    end

    assign shot[g]              = shot_q;
    assign dry_fire[g]          = dry_q;
    assign empty[g]             = empty_q;
    assign ammo[g*AW +: AW]     = ammo_q;
  end

endmodule

// File: tb/tb_gun_trigger_ctrl.sv
// Self-checking bench for gun_trigger_ctrl (2 guns, debounce 4, cooldown 3,
// 3 rounds). Stimulus pushes expected events {dry, gun, ammo} into exp_q;
// a negedge monitor pops one entry per shot/dry_fire pulse it observes.
module tb_gun_trigger_ctrl;

  localparam int NG = 2;
  localparam int DB = 4;
  localparam int CD = 3;
  localparam int MA = 3;
  localparam int AW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [NG-1:0]    trigger;
  logic [NG-1:0]    reload;
  logic [NG-1:0]    shot;
  logic [NG-1:0]    dry_fire;
  logic [NG*AW-1:0] ammo;
  logic [NG-1:0]    empty;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  gun_trigger_ctrl #(
    .NUM_GUNS       (NG),
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_CYCLES(CD),
    .MAX_AMMO       (MA)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .trigger (trigger),
    .reload  (reload),
    .shot    (shot),
    .dry_fire(dry_fire),
    .ammo    (ammo),
    .empty   (empty)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] mk_ev(input bit dry, input int g, input int a);
    return {dry, 3'(g), 4'(a)};
  endfunction

  // Advance n rising edges, then step 1 time unit so drives land off-edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clean press/hold/release on gun g.
  task automatic press_cycle(input int g);
    trigger[g] = 1'b1;
    cyc(12);
    trigger[g] = 1'b0;
    cyc(12);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      for (int g = 0; g < NG; g++) begin
        if (shot[g] || dry_fire[g]) begin
          logic [7:0] act;
          act = mk_ev(dry_fire[g], g, int'(ammo[g*AW +: AW]));
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_pulse: got 0x%0h, expected no event", act);
          end else begin
            check("event", {24'd0, act}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    trigger = '0;
    reload  = '0;
    cyc(3);
    @(negedge clk);
    check("rst_shot",  shot,     '0);
    check("rst_dry",   dry_fire, '0);
    check("rst_ammo",  ammo,     {2'd3, 2'd3});
    check("rst_empty", empty,    '0);
    cyc(1);
    reset_n = 1'b1;
    cyc(10);

    // Clean press on gun 0: shot at edge 7 after the press, ammo 3->2.
    exp_q.push_back(mk_ev(0, 0, 2));
    trigger[0] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("clean_pre_shot", shot[0], 1'b0);
    @(negedge clk);
    check("clean_shot_edge7", shot[0], 1'b1);
    check("clean_ammo", ammo[1:0], 2'd2);
    cyc(15);
    trigger[0] = 1'b0;
    cyc(12);

    // Bounce: glitches of 1-3 cycles, then a stable hold -> one shot.
    exp_q.push_back(mk_ev(0, 0, 1));
    begin
      logic [1:0] lv [6];
      int         ln [6];
      lv = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
      ln = '{2, 1, 3, 2, 1, 1};
      for (int i = 0; i < 6; i++) begin
        trigger[0] = lv[i][0];
        cyc(ln[i]);
      end
    end
    trigger[0] = 1'b1;
    cyc(15);
    trigger[0] = 1'b0;
    cyc(12);
    // A lone 3-cycle pulse must not fire.
    trigger[0] = 1'b1;
    cyc(3);
    trigger[0] = 1'b0;
    cyc(15);
    check("bounce_ammo", ammo[1:0], 2'd1);

    // Reload collides with the shot edge (ammo 1): shot issued, ammo 3.
    exp_q.push_back(mk_ev(0, 0, 3));
    trigger[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    reload[0] = 1'b1;
    cyc(1);
    reload[0] = 1'b0;
    cyc(11);
    trigger[0] = 1'b0;
    cyc(12);
    check("reload_collide_ammo", ammo[1:0], 2'd3);

    // Empty gun 1: three shots then a dry fire.
    exp_q.push_back(mk_ev(0, 1, 2));
    press_cycle(1);
    exp_q.push_back(mk_ev(0, 1, 1));
    press_cycle(1);
    exp_q.push_back(mk_ev(0, 1, 0));
    press_cycle(1);
    check("empty_after_3", empty, 2'b10);
    exp_q.push_back(mk_ev(1, 1, 0));
    press_cycle(1);
    check("dry_ammo", ammo[3:2], 2'd0);
    reload[1] = 1'b1;
    cyc(1);
    reload[1] = 1'b0;
    cyc(1);
    check("reload_ammo", ammo, {2'd3, 2'd3});
    check("reload_empty", empty, 2'b00);

    // Simultaneous presses on both guns.
    exp_q.push_back(mk_ev(0, 0, 2));
    exp_q.push_back(mk_ev(0, 1, 2));
    trigger = 2'b11;
    cyc(12);
    trigger = 2'b00;
    cyc(12);

    // Enable low: presses ignored, ammo preserved.
    enable  = 1'b0;
    trigger = 2'b11;
    cyc(15);
    check("disabled_ammo", ammo, {2'd2, 2'd2});
    trigger = 2'b00;
    cyc(12);
    enable = 1'b1;
    cyc(4);

    // Trigger held through reset never fires.
    trigger[0] = 1'b1;
    cyc(1);
    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(15);
    check("held_reset_ammo", ammo, {2'd3, 2'd3});
    trigger[0] = 1'b0;
    cyc(12);

    // Reset asserted during cooldown clears everything at once.
    exp_q.push_back(mk_ev(0, 0, 2));
    trigger[0] = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("cooldown_rst_shot",  shot,  '0);
    check("cooldown_rst_ammo",  ammo,  {2'd3, 2'd3});
    check("cooldown_rst_empty", empty, '0);
    trigger[0] = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(10);

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gun_trigger_ctrl.md
# gun_trigger_ctrl

Multi-gun trigger controller for the light-gun game. It turns each raw trigger into at most one debounced `shot` pulse per press, and enforces a release-before-refire rule, a per-gun ammunition count and a post-shot cooldown. It sits between the gun trigger pins and the hit-detection and scoring logic. The round controller refills ammo through `reload`.

## Interface
- `NUM_GUNS`, default 2: number of independent gun channels.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles (≥1) required to change the filtered trigger level.
- `COOLDOWN_CYCLES`, default 8: dead cycles after each shot; 0 is legal.
- `MAX_AMMO`, default 3: shots per reload (≥1). `AW = $clog2(MAX_AMMO+1)`.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: game-active qualifier.
- `trigger` in `NUM_GUNS`: raw asynchronous trigger, 1 = pressed.
- `reload` in `NUM_GUNS`: one-cycle refill request per gun.
- `shot` out `NUM_GUNS`: one-cycle registered fire pulse.
- `dry_fire` out `NUM_GUNS`: one-cycle pulse when a press occurs with zero ammo.
- `ammo` out `NUM_GUNS*AW`: remaining ammo; gun i occupies bits `[i*AW +: AW]`.
- `empty` out `NUM_GUNS`: 1 when that gun's ammo is 0.

## Operation
Each channel is fully independent.

- **Input conditioning:** 2-flop synchronizer, then a debounce counter. The filtered level `trig_f` toggles on the edge at which the synchronized value has differed from `trig_f` for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing cycle clears the counter.
- **States:** `S_WAIT_RELEASE`, `S_READY`, `S_SHOT`, `S_COOLDOWN`.
  - `S_WAIT_RELEASE`: go to `S_READY` when `trig_f`=0 and `enable`=1.
  - `S_READY`, with `trig_f`=1:
    - If ammo>0: go to `S_SHOT` and decrement ammo on the same edge.
    - If ammo==0: pulse `dry_fire`, go to `S_WAIT_RELEASE`.
  - `S_SHOT`: lasts one cycle; `shot`=1. Go to `S_COOLDOWN`, or to `S_WAIT_RELEASE` if `COOLDOWN_CYCLES`=0.
  - `S_COOLDOWN`: counts `COOLDOWN_CYCLES` cycles, then goes to `S_WAIT_RELEASE`. Presses during cooldown are ignored. A held trigger therefore never auto-fires.
- **enable:** `enable`=0 forces any state to `S_WAIT_RELEASE` on the next edge. An `S_SHOT` cycle already in progress still completes its pulse. Ammo is preserved.
- **reload:**
  - Loads ammo with `MAX_AMMO` in any state.
  - Reload on the same edge as the `S_READY`→`S_SHOT` transition: the shot is still issued, and ammo ends at `MAX_AMMO` (reload has priority over the decrement).
  - Reload on the same edge as a dry-fire: the dry-fire is still reported, and ammo = `MAX_AMMO`.
- **Width rules:** ammo never underflows or exceeds `MAX_AMMO`. The cooldown counter is `$clog2(COOLDOWN_CYCLES+1)` bits wide (minimum 1).

## Timing
- **Reset values:** state `S_WAIT_RELEASE`; `trig_f`=1, so a trigger held through reset cannot fire. Synchronizers 0, counters 0, ammo=`MAX_AMMO`, `shot`=0, `dry_fire`=0, `empty`=0.
- **Press latency:** a raw press stable from edge 0 gives `trig_f`=1 at edge `DEBOUNCE_CYCLES+2`. `S_SHOT` is entered, `shot` rises and `ammo`/`empty` update at edge `DEBOUNCE_CYCLES+3`.
- **Refire spacing:** minimum spacing between `shot` pulses is 1 + `COOLDOWN_CYCLES` + 1 (`S_WAIT_RELEASE`) + 1 (`S_READY`) cycles, plus release/press debounce time.
- **Reset mid-operation:** a `reset_n` assertion mid-operation clears everything asynchronously, including a `shot` pulse in flight.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- **Package `duckhunt_pkg`:** the `gun_state_t` enum (`S_WAIT_RELEASE`=2'b00, `S_READY`=2'b01, `S_SHOT`=2'b11, `S_COOLDOWN`=2'b10) and the default parameter constants.
- **Sub-module `trigger_debounce`:** synchronizer plus debounce counter, parametrised by `DEBOUNCE_CYCLES`, reset value 1. It is instantiated `NUM_GUNS` times in a generate loop. The FSM, ammo counter and cooldown counter are per-channel logic in the top module.

## Test plan
All scenarios use `NUM_GUNS`=2, `DEBOUNCE_CYCLES`=4, `COOLDOWN_CYCLES`=3, `MAX_AMMO`=3.
- **Clean press:** reset, release gun 0 for 10 cycles, then press and hold it → exactly one `shot[0]` at edge 7 after the press; `ammo[0]` 3→2; no further shot while held.
- **Bounce:** gun 0 press with 1–3 cycle glitches toggling before a stable hold → one `shot[0]` only. A 3-cycle pulse alone → no shot.
- **Empty / dry fire:** 4 clean presses on gun 1 → shots on presses 1–3, ammo 2,1,0; `empty[1]`=1. The 4th press gives `dry_fire[1]` for one cycle and no shot.
- **Reload collision:** `ammo[0]`=1 and `reload[0]` asserted on the shot edge → `shot[0]`=1, `ammo[0]`=3.
- **Simultaneous guns, enable gating:** both guns press together → simultaneous shots on both. With `enable`=0, presses → no shots, ammo unchanged.
- **Reset mid-operation:** trigger held through reset → no shot until released and re-pressed. Asserting `reset_n` low during `S_COOLDOWN` → `ammo`=3, `shot`=0 immediately.
